// File: rtl/pipe_adder_pkg.sv
// Shared FSM state type and default geometry for the chunked serial adder.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  // Counter width for n chunks; a single chunk still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; one slice of the serial add.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);

endmodule

// File: rtl/pipe_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle LSB-first, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  assign base = BW'(32'(idx_q) * CHUNK);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[base +: CHUNK]),
    .b    (b_q[base +: CHUNK]),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef PIPE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;  // subtract is a + ~b + 1, so cin is ignored
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_cout;
          idx_d   = '0;
          state_d = DONE;
`ifdef PIPE_ADDER_OVF_EN
          // Top chunk carries the result sign bit.
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: default 32/4 build plus a single-chunk 32/32 build.
module tb_pipe_adder;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;

  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, cout2, ovf2;
  logic [31:0] sum2;

  int checks = 0;
  int failures = 0;

  pipe_adder #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(1'b0), .sub(1'b0), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic ec, input logic eo, input int hold, input bit pulse);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_in_ready"}, in_ready, 1);
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b0; sub = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (pulse && n == 2) begin in_valid = 1'b1; a = 32'h1111; b = 32'h2222; end
      else in_valid = 1'b0;
      if (pulse && n == 3) check({tag, "_rdy_in_run"}, in_ready, 0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo & OVF_ON);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_rdy_in_done"}, in_ready, 0);
      tick();
      check({tag, "_hold_vld"}, out_valid, 1);
      check({tag, "_hold_sum"}, sum, es);
      check({tag, "_hold_cout"}, cout, ec);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, out_valid, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
    if (pulse) begin
      n = 0;
      repeat (12) begin if (out_valid) n++; tick(); end
      check({tag, "_no_queued"}, n, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready32", in_ready2, 1);

    do_op("add_5_7",   32'd5,         32'd7,         1'b0, 1'b0, 32'd12,        1'b0, 1'b0, 0, 1'b0);
    do_op("add_cin",   32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 0, 1'b0);
    do_op("add_povf",  32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
    do_op("add_novf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b1, 1'b1, 0, 1'b0);
    do_op("add_mix",   32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub_3_5",   32'd3,         32'd5,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub_5_3",   32'd5,         32'd3,         1'b0, 1'b1, 32'd2,         1'b1, 1'b0, 0, 1'b0);
    do_op("sub_cinig", 32'd10,        32'd4,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0, 0, 1'b0);
    do_op("hold",      32'h0000_00FF, 32'd1,         1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 3, 1'b1);

    // Abort mid-run: reset in the 4th RUN cycle, with in_valid also high.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    n = 0;
    repeat (12) begin if (out_valid) n++; tick(); end
    check("abort_no_vld", n, 0);
    do_op("after_abort", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 0, 1'b0);

    // Single-chunk build: one RUN cycle.
    a2 = 32'd10; b2 = 32'd20; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    check("c32_rdy_run", in_ready2, 0);
    tick();
    check("c32_vld", out_valid2, 1);
    check("c32_sum", sum2, 32'd30);
    check("c32_cout", cout2, 0);
    check("c32_ovf", ovf2, 0);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("c32_rdy_back", in_ready2, 1);
    check("c32_vld_drop", out_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
